ghost_motion_ctrl: RTL and testbench

//  Per-ghost position/motion controller, directly upstream of the ghost bitmap stage.

---
 rtl/ghost_pkg.sv | 30 +++
 rtl/ghost_dir_select.sv | 38 +++
 rtl/ghost_motion_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ghost_motion_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared types, constants and helpers for the ghost motion blocks.
package ghost_pkg;

  localparam int unsigned POS_W    = 11;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned TILE     = 16;
  localparam int unsigned OBJ_SIZE = 16;
  localparam int unsigned TILE_LSB = $clog2(TILE);

  localparam logic [1:0] FRIGHTENED_MODE = 2'd2;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    HOME  = 2'd0,
    ROAM  = 2'd1,
    EATEN = 2'd2
  } ghost_state_t;

  // Opposite direction: the encoding pairs opposites on bit 0.
  function automatic dir_t reverse(input dir_t d);
    reverse = dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/ghost_dir_select.sv
// Tile-centre direction chooser: requested, then current, then fixed priority, then reverse.
module ghost_dir_select
  import ghost_pkg::*;
(
  input  logic [1:0] orientation_i,
  input  logic [1:0] next_dir_i,
  input  logic [3:0] blocked_i,
  output logic [1:0] new_dir_c_o
);

  dir_t orient;
  dir_t req;
  dir_t rev;
  dir_t pick;

  // Pick the new travel direction; reversing is the last resort.
  always_comb begin
    orient = dir_t'(orientation_i);
    req    = dir_t'(next_dir_i);
    rev    = reverse(orient);
    pick   = rev;
    if (!blocked_i[req] && (req != rev)) begin
      pick = req;
    end else if (!blocked_i[orient]) begin
      pick = orient;
    end else if (!blocked_i[UP] && (rev != UP)) begin
      pick = UP;
    end else if (!blocked_i[LEFT] && (rev != LEFT)) begin
      pick = LEFT;
    end else if (!blocked_i[DOWN] && (rev != DOWN)) begin
      pick = DOWN;
    end else if (!blocked_i[RIGHT] && (rev != RIGHT)) begin
      pick = RIGHT;
    end
    new_dir_c_o = pick;
  end

endmodule

// File: rtl/ghost_motion_ctrl.sv
// Per-ghost position/motion controller feeding the ghost bitmap stage.
module ghost_motion_ctrl
  import ghost_pkg::*;
#(
  parameter logic [1:0]  GHOSTNUM       = 2'd0,
  parameter logic [10:0] INIT_X         = 11'd304,
  parameter logic [10:0] INIT_Y         = 11'd224,
  parameter logic [7:0]  RELEASE_FRAMES = 8'd60,
  parameter logic [7:0]  EATEN_FRAMES   = 8'd120,
  parameter logic [10:0] X_MAX          = 11'd624
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start_of_frame,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic [1:0]  next_dir,
  input  logic [3:0]  blocked,
  input  logic [1:0]  game_mode,
  input  logic        ghost_eaten,
  output logic [10:0] offset_x,
  output logic [10:0] offset_y,
  output logic        in_container,
  output logic [1:0]  orientation,
  output logic [10:0] top_left_x,
  output logic [10:0] top_left_y
);

  localparam logic [10:0] RELEASE_THR = 11'(RELEASE_FRAMES) * (11'(GHOSTNUM) + 11'd1);
  localparam logic [10:0] EATEN_THR   = 11'(EATEN_FRAMES);
  localparam logic [11:0] BOX_SPAN    = 12'(OBJ_SIZE - 1);

  ghost_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  dir_t             orient_q, orient_d;
  logic [1:0]       prev_mode_q, prev_mode_d;
  logic [POS_W-1:0] offset_x_q, offset_x_d, offset_y_q, offset_y_d;
  logic             in_cont_q, in_cont_d;

  logic [1:0]  sel_dir;
  logic        centre;
  logic        frightened;
  logic        forced_rev;
  logic        step_en;
  dir_t        step_dir;
  logic        eaten_hit;
  logic [10:0] cnt_inc;

  ghost_dir_select u_dir_select (
    .orientation_i (orient_q),
    .next_dir_i    (next_dir),
    .blocked_i     (blocked),
    .new_dir_c_o   (sel_dir)
  );

  // Roaming direction and step enable for the current frame.
  always_comb begin
    centre     = (x_q[TILE_LSB-1:0] == '0) && (y_q[TILE_LSB-1:0] == '0);
    frightened = (game_mode == FRIGHTENED_MODE);
    forced_rev = frightened && (prev_mode_q != FRIGHTENED_MODE);
    eaten_hit  = ghost_eaten && (state_q == ROAM) && frightened;
    cnt_inc    = 11'(cnt_q) + 11'd1;
    step_dir   = orient_q;
    if (forced_rev) begin
      step_dir = reverse(orient_q);
    end else if (centre) begin
      step_dir = dir_t'(sel_dir);
    end
    // The forced-reverse frame always steps so the turn is visible immediately.
    step_en = forced_rev || !frightened || cnt_q[0];
  end

  // Frame-strobed FSM, counters and position update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    orient_d    = orient_q;
    prev_mode_d = prev_mode_q;
    if (start_of_frame) begin
      prev_mode_d = game_mode;
    end
    if (eaten_hit) begin
      state_d = EATEN;
      cnt_d   = '0;
    end else if (start_of_frame) begin
      case (state_q)
        HOME: begin
          if (cnt_inc == RELEASE_THR) begin
            state_d  = ROAM;
            orient_d = UP;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ROAM: begin
          cnt_d    = cnt_q + CNT_W'(1);
          orient_d = step_dir;
          if (step_en) begin
            case (step_dir)
              UP:    y_d = y_q - POS_W'(1);
              DOWN:  y_d = y_q + POS_W'(1);
              LEFT:  x_d = (x_q == '0) ? X_MAX : x_q - POS_W'(1);
              RIGHT: x_d = (x_q == X_MAX) ? '0 : x_q + POS_W'(1);
              default: x_d = x_q;
            endcase
          end
        end
        EATEN: begin
          if (cnt_inc == EATEN_THR) begin
            state_d  = HOME;
            x_d      = INIT_X;
            y_d      = INIT_Y;
            orient_d = UP;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = HOME;
      endcase
    end
  end

  // Pixel path: offsets and box hit, one clock behind the raster.
  always_comb begin
    offset_x_d = pixel_x - x_q;
    offset_y_d = pixel_y - y_q;
    in_cont_d  = (state_q != EATEN)
              && ({1'b0, pixel_x} >= {1'b0, x_q}) && ({1'b0, pixel_x} <= ({1'b0, x_q} + BOX_SPAN))
              && ({1'b0, pixel_y} >= {1'b0, y_q}) && ({1'b0, pixel_y} <= ({1'b0, y_q} + BOX_SPAN));
  end

  // State and pixel-path registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= HOME;
      cnt_q       <= '0;
      x_q         <= INIT_X;
      y_q         <= INIT_Y;
      orient_q    <= UP;
      prev_mode_q <= '0;
      offset_x_q  <= '0;
      offset_y_q  <= '0;
      in_cont_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      orient_q    <= orient_d;
      prev_mode_q <= prev_mode_d;
      offset_x_q  <= offset_x_d;
      offset_y_q  <= offset_y_d;
      in_cont_q   <= in_cont_d;
    end
  end

  assign offset_x     = offset_x_q;
  assign offset_y     = offset_y_q;
  assign in_container = in_cont_q;
  assign orientation  = orient_q;
  assign top_left_x   = x_q;
  assign top_left_y   = y_q;

endmodule

// File: tb/tb_ghost_motion_ctrl.sv
// Directed bench for ghost_motion_ctrl (GHOSTNUM=1, RELEASE_FRAMES=3) and its chooser.
module tb_ghost_motion_ctrl;

  localparam logic [1:0] D_UP = 2'd0;
  localparam logic [1:0] D_DN = 2'd1;
  localparam logic [1:0] D_LT = 2'd2;
  localparam logic [1:0] D_RT = 2'd3;
  localparam logic [1:0] M_N  = 2'd0;
  localparam logic [1:0] M_FR = ghost_pkg::FRIGHTENED_MODE;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start_of_frame;
  logic [10:0] pixel_x, pixel_y;
  logic [1:0]  next_dir;
  logic [3:0]  blocked;
  logic [1:0]  game_mode;
  logic        ghost_eaten;
  logic [10:0] offset_x, offset_y, top_left_x, top_left_y;
  logic        in_container;
  logic [1:0]  orientation;

  logic [1:0] sel_orient, sel_next, sel_out;
  logic [3:0] sel_blk;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ghost_motion_ctrl #(
    .GHOSTNUM       (2'd1),
    .INIT_X         (11'd304),
    .INIT_Y         (11'd224),
    .RELEASE_FRAMES (8'd3),
    .EATEN_FRAMES   (8'd120),
    .X_MAX          (11'd624)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .start_of_frame (start_of_frame),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .next_dir       (next_dir),
    .blocked        (blocked),
    .game_mode      (game_mode),
    .ghost_eaten    (ghost_eaten),
    .offset_x       (offset_x),
    .offset_y       (offset_y),
    .in_container   (in_container),
    .orientation    (orientation),
    .top_left_x     (top_left_x),
    .top_left_y     (top_left_y)
  );

  ghost_dir_select u_sel (
    .orientation_i (sel_orient),
    .next_dir_i    (sel_next),
    .blocked_i     (sel_blk),
    .new_dir_c_o   (sel_out)
  );

  typedef struct {
    int         reps;
    logic [1:0] nd;
    logic [3:0] blk;
    logic [1:0] md;
    logic       eat;
    logic [10:0] ex;
    logic [10:0] ey;
    logic [1:0] eo;
  } vec_t;

  typedef struct {
    logic [1:0] orient;
    logic [1:0] nd;
    logic [3:0] blk;
    logic [1:0] exp_dir;
  } sel_vec_t;

  localparam int NV = 28;
  localparam int NS = 10;
  vec_t     vecs[NV];
  sel_vec_t svecs[NS];

  function automatic vec_t mk(input int r, input logic [1:0] nd, input logic [3:0] blk,
                              input logic [1:0] md, input logic eat,
                              input int ex, input int ey, input logic [1:0] eo);
    vec_t v;
    v.reps = r; v.nd = nd; v.blk = blk; v.md = md; v.eat = eat;
    v.ex = 11'(ex); v.ey = 11'(ey); v.eo = eo;
    return v;
  endfunction

  function automatic sel_vec_t mks(input logic [1:0] o, input logic [1:0] nd,
                                   input logic [3:0] blk, input logic [1:0] e);
    sel_vec_t s;
    s.orient = o; s.nd = nd; s.blk = blk; s.exp_dir = e;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame: strobe with the given inputs, then let it settle.
  task automatic run_frame(input logic [1:0] nd, input logic [3:0] blk,
                           input logic [1:0] md, input logic eat);
    next_dir       = nd;
    blocked        = blk;
    game_mode      = md;
    ghost_eaten    = eat;
    start_of_frame = 1'b1;
    @(posedge clk); #1;
    start_of_frame = 1'b0;
    ghost_eaten    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        run_frame(vecs[i].nd, vecs[i].blk, vecs[i].md, vecs[i].eat);
      end
      check($sformatf("vec%0d_x", i), int'(top_left_x), int'(vecs[i].ex));
      check($sformatf("vec%0d_y", i), int'(top_left_y), int'(vecs[i].ey));
      check($sformatf("vec%0d_orient", i), int'(orientation), int'(vecs[i].eo));
    end
  endtask

  task automatic pixel_check(input string name, input int px, input int py,
                             input int eox, input int eoy, input int ein);
    pixel_x = 11'(px);
    pixel_y = 11'(py);
    @(posedge clk); #1;
    check({name, "_offx"}, int'(offset_x), eox);
    check({name, "_offy"}, int'(offset_y), eoy);
    check({name, "_in"}, int'(in_container), ein);
    pixel_x = '0;
    pixel_y = '0;
  endtask

  initial begin
    // Frame-level vectors: {reps, next_dir, blocked, mode, eaten} -> {x, y, orientation}.
    vecs[0]  = mk(3,   D_DN, 4'b0000, M_N,  0, 304, 224, D_UP);
    vecs[1]  = mk(1,   D_DN, 4'b0000, M_FR, 1, 304, 224, D_UP);
    vecs[2]  = mk(1,   D_DN, 4'b0000, M_N,  0, 304, 224, D_UP);
    vecs[3]  = mk(1,   D_DN, 4'b0000, M_N,  0, 304, 224, D_UP);
    vecs[4]  = mk(1,   D_LT, 4'b0000, M_N,  0, 303, 224, D_LT);
    vecs[5]  = mk(1,   D_UP, 4'b1111, M_N,  0, 302, 224, D_LT);
    vecs[6]  = mk(14,  D_RT, 4'b0000, M_N,  0, 288, 224, D_LT);
    vecs[7]  = mk(16,  D_RT, 4'b0000, M_N,  0, 272, 224, D_LT);
    vecs[8]  = mk(1,   D_UP, 4'b0101, M_N,  0, 272, 225, D_DN);
    vecs[9]  = mk(15,  D_UP, 4'b1111, M_N,  0, 272, 240, D_DN);
    vecs[10] = mk(1,   D_LT, 4'b1110, M_N,  0, 272, 239, D_UP);
    vecs[11] = mk(15,  D_DN, 4'b0000, M_N,  0, 272, 224, D_UP);
    vecs[12] = mk(1,   D_DN, 4'b0001, M_N,  0, 271, 224, D_LT);
    vecs[13] = mk(271, D_LT, 4'b0000, M_N,  0, 0,   224, D_LT);
    vecs[14] = mk(1,   D_LT, 4'b0000, M_N,  0, 624, 224, D_LT);
    vecs[15] = mk(1,   D_LT, 4'b0000, M_N,  0, 623, 224, D_LT);
    vecs[16] = mk(1,   D_LT, 4'b0000, M_FR, 0, 624, 224, D_RT);
    vecs[17] = mk(1,   D_RT, 4'b0000, M_FR, 0, 0,   224, D_RT);
    vecs[18] = mk(1,   D_RT, 4'b0000, M_FR, 0, 0,   224, D_RT);
    vecs[19] = mk(1,   D_RT, 4'b0000, M_FR, 0, 1,   224, D_RT);
    vecs[20] = mk(1,   D_RT, 4'b0000, M_FR, 0, 1,   224, D_RT);
    vecs[21] = mk(1,   D_RT, 4'b0000, M_FR, 1, 1,   224, D_RT);
    vecs[22] = mk(119, D_UP, 4'b0000, M_N,  0, 1,   224, D_RT);
    vecs[23] = mk(1,   D_UP, 4'b0000, M_N,  0, 304, 224, D_UP);
    vecs[24] = mk(5,   D_DN, 4'b0000, M_N,  0, 304, 224, D_UP);
    vecs[25] = mk(1,   D_DN, 4'b0000, M_N,  0, 304, 224, D_UP);
    vecs[26] = mk(1,   D_UP, 4'b0000, M_N,  0, 304, 223, D_UP);
    vecs[27] = mk(1,   D_UP, 4'b0000, M_N,  1, 304, 222, D_UP);

    // Chooser vectors: {orientation, next_dir, blocked} -> chosen direction.
    svecs[0] = mks(D_UP, D_LT, 4'b0000, D_LT);
    svecs[1] = mks(D_UP, D_DN, 4'b0000, D_UP);
    svecs[2] = mks(D_UP, D_LT, 4'b0100, D_UP);
    svecs[3] = mks(D_UP, D_RT, 4'b1001, D_LT);
    svecs[4] = mks(D_LT, D_UP, 4'b0101, D_DN);
    svecs[5] = mks(D_DN, D_LT, 4'b1110, D_UP);
    svecs[6] = mks(D_RT, D_DN, 4'b1110, D_UP);
    svecs[7] = mks(D_RT, D_LT, 4'b0111, D_RT);
    svecs[8] = mks(D_LT, D_RT, 4'b1111, D_RT);
    svecs[9] = mks(D_DN, D_RT, 4'b0000, D_RT);

    resetN = 1'b0; start_of_frame = 1'b0; ghost_eaten = 1'b0;
    pixel_x = '0; pixel_y = '0; next_dir = D_UP; blocked = '0; game_mode = M_N;
    sel_orient = '0; sel_next = '0; sel_blk = '0;

    for (int i = 0; i < NS; i++) begin
      sel_orient = svecs[i].orient;
      sel_next   = svecs[i].nd;
      sel_blk    = svecs[i].blk;
      #1;
      check($sformatf("sel%0d", i), int'(sel_out), int'(svecs[i].exp_dir));
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_x", int'(top_left_x), 304);
    check("rst_y", int'(top_left_y), 224);
    check("rst_orient", int'(orientation), int'(D_UP));
    check("rst_offx", int'(offset_x), 0);
    check("rst_offy", int'(offset_y), 0);
    check("rst_in", int'(in_container), 0);
    resetN = 1'b1;
    @(posedge clk); #1;

    pixel_check("pix_inside", 305, 230, 1, 6, 1);
    pixel_check("pix_right_edge", 320, 224, 16, 0, 0);
    pixel_check("pix_corner", 319, 239, 15, 15, 1);
    pixel_check("pix_left_out", 303, 224, 2047, 0, 0);

    run_range(0, 21);
    pixel_check("pix_eaten", 5, 230, 4, 6, 0);
    run_range(22, NV - 1);
    pixel_check("pix_back", 305, 230, 1, 8, 1);

    // Asynchronous reset mid-run restores initial state.
    #2 resetN = 1'b0;
    #1;
    check("rst2_x", int'(top_left_x), 304);
    check("rst2_y", int'(top_left_y), 224);
    check("rst2_in", int'(in_container), 0);
    check("rst2_offy", int'(offset_y), 0);
    resetN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
